// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: ISA fields, FSM states, ALU control.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2
    } src_b_t;

    typedef enum logic [1:0] {
        PC_ALU, PC_ALUOUT, PC_JUMP
    } pc_src_t;

    // Single shared ALU; all arithmetic wraps, slt is signed.
    function automatic logic [XLEN-1:0] alu_eval(input alu_ctrl_t ctrl,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (ctrl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
            default: return '0;
        endcase
    endfunction

    // R-type funct to ALU operation.
    function automatic alu_ctrl_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Opcode/funct combinations the core implements.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
                    default:                               return 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Control FSM: sequences each instruction and produces datapath enables and memory strobes.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ack,
    input  logic       a_eq_b,
    input  logic [1:0] addr_lo,
    output logic       pc_we_c,
    output pc_src_t    pc_src_c,
    output logic       ir_we_c,
    output logic       mdr_we_c,
    output logic       ab_we_c,
    output logic       aluout_we_c,
    output logic       src_a_pc_c,
    output src_b_t     src_b_c,
    output alu_ctrl_t  alu_ctrl_c,
    output logic       reg_we_c,
    output logic       reg_dst_rd_c,
    output logic       wb_mdr_c,
    output logic       iord_c,
    output logic       mem_req_c,
    output logic       mem_we_c,
    output logic       retire_c,
    output logic       trap_c
);

    state_t state_q;
    state_t state_d;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        pc_we_c      = 1'b0;
        pc_src_c     = PC_ALU;
        ir_we_c      = 1'b0;
        mdr_we_c     = 1'b0;
        ab_we_c      = 1'b0;
        aluout_we_c  = 1'b0;
        src_a_pc_c   = 1'b0;
        src_b_c      = SRCB_B;
        alu_ctrl_c   = ALU_ADD;
        reg_we_c     = 1'b0;
        reg_dst_rd_c = 1'b0;
        wb_mdr_c     = 1'b0;
        iord_c       = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        retire_c     = 1'b0;
        trap_c       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                src_a_pc_c = 1'b1;
                src_b_c    = SRCB_FOUR;
                if (mem_ack) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_we_c     = 1'b1;
                aluout_we_c = 1'b1;
                src_a_pc_c  = 1'b1;
                src_b_c     = SRCB_IMM_SH2;
                if (!is_legal(opcode, funct)) begin
                    state_d = S_TRAP;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_ADDI:        state_d = S_ADDIEX;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        default:        state_d = S_EXEC;
                    endcase
                end
            end
            S_MEMADR: begin
                aluout_we_c = 1'b1;
                src_b_c     = SRCB_IMM;
                if (addr_lo != 2'b00)    state_d = S_TRAP;
                else if (opcode == OP_LW) state_d = S_MEMRD;
                else                      state_d = S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem_ack) begin
                    mdr_we_c = 1'b1;
                    state_d  = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_we_c = 1'b1;
                wb_mdr_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (mem_ack) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC: begin
                aluout_we_c = 1'b1;
                alu_ctrl_c  = funct_to_alu(funct);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_c     = 1'b1;
                reg_dst_rd_c = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                aluout_we_c = 1'b1;
                src_b_c     = SRCB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                pc_src_c = PC_ALUOUT;
                pc_we_c  = a_eq_b ^ (opcode == OP_BNE);
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c = PC_JUMP;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset state is FETCH, but no request may be visible while reset is held.
        if (reset) begin
            mem_req_c = 1'b0;
            mem_we_c  = 1'b0;
        end
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: shared ALU, unified req/ack memory port, retire strobe and sticky trap.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic              trap
);

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0]       rf_q [32];

    logic      pc_we, ir_we, mdr_we, ab_we, aluout_we, src_a_pc;
    logic      reg_we, reg_dst_rd, wb_mdr, iord;
    pc_src_t   pc_src;
    src_b_t    src_b;
    alu_ctrl_t alu_ctrl;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, wa;
    logic [31:0]       sext, src_a_v, src_b_v, alu_y, rs_data, rt_data, wd;
    logic [ADDR_W-1:0] jump_target;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};

    mips_mc_control u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .mem_ack      (mem_ack),
        .a_eq_b       (a_q == b_q),
        .addr_lo      (alu_y[1:0]),
        .pc_we_c      (pc_we),
        .pc_src_c     (pc_src),
        .ir_we_c      (ir_we),
        .mdr_we_c     (mdr_we),
        .ab_we_c      (ab_we),
        .aluout_we_c  (aluout_we),
        .src_a_pc_c   (src_a_pc),
        .src_b_c      (src_b),
        .alu_ctrl_c   (alu_ctrl),
        .reg_we_c     (reg_we),
        .reg_dst_rd_c (reg_dst_rd),
        .wb_mdr_c     (wb_mdr),
        .iord_c       (iord),
        .mem_req_c    (mem_req),
        .mem_we_c     (mem_we),
        .retire_c     (retire),
        .trap_c       (trap)
    );

    // Jump keeps the PC segment bits when the address space is wider than the target field.
    if (ADDR_W > 28) begin : g_jt_wide
        assign jump_target = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
    end else begin : g_jt_narrow
        assign jump_target = ADDR_W'({ir_q[25:0], 2'b00});
    end

    // Register file read ports; $0 is hardwired to zero.
    always_comb begin
        rs_data = (rs == 5'd0) ? 32'd0 : rf_q[rs];
        rt_data = (rt == 5'd0) ? 32'd0 : rf_q[rt];
        wa      = reg_dst_rd ? rd : rt;
        wd      = wb_mdr ? mdr_q : aluout_q;
    end

    // ALU operand selection and evaluation.
    always_comb begin
        src_a_v = src_a_pc ? 32'(pc_q) : a_q;
        case (src_b)
            SRCB_FOUR:    src_b_v = 32'd4;
            SRCB_IMM:     src_b_v = sext;
            SRCB_IMM_SH2: src_b_v = {sext[29:0], 2'b00};
            default:      src_b_v = b_q;
        endcase
        alu_y = alu_eval(alu_ctrl, src_a_v, src_b_v);
    end

    assign mem_addr  = iord ? ADDR_W'(aluout_q) : pc_q;
    assign mem_wdata = b_q;

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (pc_we) begin
            case (pc_src)
                PC_ALUOUT: pc_q <= ADDR_W'(aluout_q);
                PC_JUMP:   pc_q <= jump_target;
                default:   pc_q <= ADDR_W'(alu_y);
            endcase
        end
    end

    // Internal pipeline registers between FSM states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            if (ir_we)     ir_q     <= mem_rdata;
            if (mdr_we)    mdr_q    <= mem_rdata;
            if (ab_we)     a_q      <= rs_data;
            if (ab_we)     b_q      <= rt_data;
            if (aluout_we) aluout_q <= alu_y;
        end
    end

    // Register file write port; writes to $0 are dropped.
    always_ff @(posedge clk) begin
        if (reg_we && (wa != 5'd0)) rf_q[wa] <= wd;
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench: behavioural wait-state memory, store/fetch scoreboard, ALU vector table.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .retire    (retire),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [5:0] funct; logic [31:0] a; logic [31:0] b; logic [31:0] y; } vec_t;

    logic [31:0] mem [0:1023];
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    vec_t        vecs[8];

    int n_vec = 0, n_bad = 0;
    int cyc, n_ret, wait_n, wcnt;
    logic hold_wr, pend, sv_we;
    logic [31:0] sv_addr, sv_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        exp_wr.delete();
        exp_rd.delete();
    endtask

    // One clock of the memory model plus scoreboard and handshake-stability checks.
    task automatic cycle();
        logic ack;
        wr_t w;
        @(negedge clk);
        cyc++;
        if (pend) begin
            check("hold_req", 32'(mem_req), 32'd1);
            check("hold_we", 32'(mem_we), 32'(sv_we));
            check("hold_addr", mem_addr, sv_addr);
            check("hold_wdata", mem_wdata, sv_wdata);
        end
        ack = mem_req && (wcnt >= wait_n) && !(hold_wr && mem_we);
        mem_ack   = ack;
        mem_rdata = mem[mem_addr[11:2]];
        if (ack && mem_we) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_store: got addr %h data %h expected no store", mem_addr, mem_wdata);
            end else begin
                w = exp_wr.pop_front();
                check("store_addr", mem_addr, w.addr);
                check("store_data", mem_wdata, w.data);
            end
            mem[mem_addr[11:2]] = mem_wdata;
        end else if (ack && exp_rd.size() != 0) begin
            check("read_addr", mem_addr, exp_rd.pop_front());
        end
        pend = mem_req && !ack;
        wcnt = pend ? wcnt + 1 : 0;
        sv_we = mem_we;
        sv_addr = mem_addr;
        sv_wdata = mem_wdata;
        #1;
        if (retire) n_ret++;
    endtask

    // Asserts reset, checks outputs while held, releases just after a rising edge.
    task automatic reset_dut();
        reset = 1'b1;
        pend = 1'b0;
        wcnt = 0;
        mem_ack = 1'b0;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
        n_ret = 0;
    endtask

    task automatic run_to_trap(input int budget);
        for (int i = 0; i < budget && !trap; i++) cycle();
        check("run_timeout", 32'(trap), 32'd1);
    endtask

    task automatic run_to_retires(input int n, input int budget, input int exp_cyc);
        for (int i = 0; i < budget && n_ret < n; i++) cycle();
        check("retire_count", 32'(n_ret), 32'(n));
        check("cycle_count", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic drained();
        check("store_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("read_queue_drained", 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic load_main_prog();
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 5);
        mem[1] = enc_i(6'h08, 0, 2, 7);
        mem[2] = enc_r(6'h20, 1, 2, 3);
        mem[3] = enc_i(6'h2B, 0, 3, 'h40);
        mem[4] = enc_i(6'h23, 0, 4, 'h40);
        mem[5] = enc_i(6'h2B, 0, 4, 'h44);
        exp_wr.push_back(wr_t'{32'h40, 32'd12});
        exp_wr.push_back(wr_t'{32'h44, 32'd12});
    endtask

    task automatic load_branch_prog(input logic [5:0] br_op);
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 9, 9);
        mem[1] = enc_i(6'h08, 0, 8, 9);
        mem[2] = enc_i(6'h08, 0, 7, 3);
        mem[3] = enc_i(6'h08, 0, 6, 4);
        mem[4] = enc_i(br_op, 9, 8, 4);
        mem[5] = enc_i(6'h2B, 0, 8, 'h84);
        mem[9] = enc_j('h100);
        mem[256] = enc_i(6'h2B, 0, 9, 'h80);
        for (int a = 0; a <= 'h10; a += 4) exp_rd.push_back(32'(a));
    endtask

    initial begin
        int reqs;
        vecs[0] = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[1] = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[2] = '{6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{6'h22, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[4] = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[5] = '{6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
        vecs[6] = '{6'h20, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[7] = '{6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};

        reset = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        hold_wr = 1'b0;
        wait_n = 0;
        cyc = 0;
        n_ret = 0;
        #1;

        // Main program, zero-wait memory.
        load_main_prog();
        reset_dut();
        run_to_retires(5, 200, 21);
        run_to_trap(100);
        check("mem40", mem['h10], 32'd12);
        check("mem44", mem['h11], 32'd12);
        drained();

        // Same program with three wait states on every access.
        load_main_prog();
        wait_n = 3;
        reset_dut();
        run_to_retires(5, 400, 42);
        run_to_trap(200);
        check("mem40_wait", mem['h10], 32'd12);
        drained();
        wait_n = 0;

        // ALU vector table: lw a, lw b, op, sw result.
        foreach (vecs[i]) begin
            clear_mem();
            mem[0] = enc_i(6'h23, 0, 1, 'h200);
            mem[1] = enc_i(6'h23, 0, 2, 'h204);
            mem[2] = enc_r(vecs[i].funct, 1, 2, 3);
            mem[3] = enc_i(6'h2B, 0, 3, 'h208);
            mem['h80] = vecs[i].a;
            mem['h81] = vecs[i].b;
            exp_wr.push_back(wr_t'{32'h208, vecs[i].y});
            reset_dut();
            run_to_trap(200);
            check($sformatf("vec%0d_retires", i), 32'(n_ret), 32'd4);
            drained();
        end

        // beq taken to 0x24, then j 0x100 to 0x400.
        load_branch_prog(6'h04);
        exp_rd.push_back(32'h24);
        exp_rd.push_back(32'h400);
        exp_rd.push_back(32'h404);
        exp_wr.push_back(wr_t'{32'h80, 32'd9});
        reset_dut();
        run_to_trap(200);
        check("beq_retires", 32'(n_ret), 32'd7);
        drained();

        // Same encoding as bne falls through to 0x14.
        load_branch_prog(6'h05);
        exp_rd.push_back(32'h14);
        exp_rd.push_back(32'h18);
        exp_wr.push_back(wr_t'{32'h84, 32'd9});
        reset_dut();
        run_to_trap(200);
        check("bne_retires", 32'(n_ret), 32'd6);
        drained();

        // Illegal opcode traps at the edge ending DECODE, then stays quiet.
        clear_mem();
        mem[0] = enc_i(6'h3F, 0, 0, 0);
        reset_dut();
        cycle();
        cycle();
        check("illop_trap_decode", 32'(trap), 32'd0);
        cycle();
        check("illop_trap_set", 32'(trap), 32'd1);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (mem_req) reqs++;
        end
        check("trap_no_req", 32'(reqs), 32'd0);
        check("trap_no_retire", 32'(n_ret), 32'd0);
        check("trap_sticky", 32'(trap), 32'd1);
        exp_rd.push_back(32'h0);
        reset_dut();
        cycle();
        check("restart_fetch_req", 32'(mem_req), 32'd1);
        drained();

        // Misaligned lw traps at the edge ending MEMADR.
        clear_mem();
        mem[0] = enc_i(6'h23, 0, 4, 'h41);
        reset_dut();
        repeat (3) cycle();
        check("lw_mis_memadr", 32'(trap), 32'd0);
        cycle();
        check("lw_mis_trap", 32'(trap), 32'd1);
        check("lw_mis_retire", 32'(n_ret), 32'd0);

        // Reset during a pending write, then restart; $0 stays zero.
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 'h55);
        mem[1] = enc_i(6'h2B, 0, 1, 'h40);
        mem[2] = enc_i(6'h08, 0, 0, 5);
        mem[3] = enc_i(6'h2B, 0, 0, 'h44);
        hold_wr = 1'b1;
        reset_dut();
        for (int i = 0; i < 50 && !(pend && mem_we); i++) cycle();
        check("wr_pending", 32'(pend && mem_we), 32'd1);
        check("wr_pending_addr", mem_addr, 32'h40);
        check("wr_pending_data", mem_wdata, 32'h55);
        #2 reset = 1'b1;
        #1;
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_we_drop", 32'(mem_we), 32'd0);
        hold_wr = 1'b0;
        exp_rd.push_back(32'h0);
        exp_wr.push_back(wr_t'{32'h40, 32'h55});
        exp_wr.push_back(wr_t'{32'h44, 32'h0});
        reset_dut();
        run_to_trap(200);
        check("restart_retires", 32'(n_ret), 32'd4);
        drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
